fc_score_argmax: RTL
====================

Name: fc_score_argmax

Overview:
- Sits at the write end of the final fully-connected layer: drives that layer's start, captures its per-neuron output writes into a score buffer, and completes the start/done handshake.
- After the layer finishes, scans the buffer and presents the winning class index and score on a valid/ready output.
- Flags out-of-range writes and missing writes.

Parameters:
- NUM_CLASSES, 10, number of output neurons / score entries (2..16)
- ADDR_W, 10, width of layer write address
- DATA_W, 8, width of score (unsigned)
- CLASS_W, 4, width of class index; must satisfy 2^CLASS_W >= NUM_CLASSES

Ports:
- clk  in  1  clock
- rst  in  1  reset
- go  in  1  single-cycle request to run one inference; ignored unless in IDLE
- busy  out  1  high in every state except IDLE
- layer_start  out  1  start level to producer layer
- layer_wr_addr  in  ADDR_W  producer write address (neuron index)
- layer_wr_data  in  DATA_W  producer write data (unsigned score)
- layer_wr_en  in  1  producer write strobe
- layer_done  in  1  producer done level
- class_id  out  CLASS_W  winning class index
- class_score  out  DATA_W  winning score
- class_valid  out  1  result valid
- class_ready  in  1  consumer accepts result
- status  out  3  sticky flags: [0] range error, [1] missing score, [2] timeout

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: state IDLE; layer_start=0, class_valid=0, class_id=0, class_score=0, status=0, busy=0. The written mask and the internal index/best registers clear. Score buffer contents are don't-care. Reset mid-operation aborts immediately; layer_start drops on the reset edge.
- States: IDLE, RUN, RELEASE, SCAN, HOLD.
- IDLE: on go, clear the written mask and status, set layer_start<=1, go to RUN.
- RUN, write capture: on any cycle with layer_wr_en=1:
  - If addr < NUM_CLASSES: score[addr]<=data and written[addr]<=1. A repeated write to the same address overwrites; last write wins.
  - If addr >= NUM_CLASSES: no buffer change; set status[0].
- RUN, exit: when layer_done=1, set layer_start<=0 and go to RELEASE. A write in the same cycle as layer_done=1 is still captured.
- RELEASE:
  - Writes are ignored.
  - Wait for layer_done=0, which is the producer's return to idle. On seeing layer_done=0, set idx<=0, best_id<=0, best_score<=0, and go to SCAN.
- SCAN:
  - Take one entry per cycle, idx 0..NUM_CLASSES-1.
  - If written[idx]=0, set status[1] and treat the score as 0.
  - Update best when score > best_score (strict), so the lowest index wins ties.
  - After entry NUM_CLASSES-1, register class_id/class_score and set class_valid<=1.
  - SCAN lasts exactly NUM_CLASSES cycles.
  - If all scores are 0, class_id=0 and class_score=0.
- HOLD:
  - class_valid, class_id and class_score stay stable until class_valid&&class_ready.
  - On that cycle class_valid<=0 and the state returns to IDLE.
  - class_id/class_score keep their last values after the handshake. status keeps its value until the next go.
- Latency:
  - go at edge N → layer_start=1 after edge N.
  - First cycle of layer_done=0 in RELEASE at edge M → class_valid=1 after edge M+NUM_CLASSES.
  - If class_ready is held high, class_valid is high for exactly 1 cycle.
- go asserted while busy: ignored, no side effect.
- Arithmetic: comparisons are unsigned DATA_W; no accumulation, no overflow path.

Optional Feature:
- Macro FC_SCORE_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 4096) and a 16-bit counter cleared on entry to RUN and incremented each RUN cycle.
  - If the count reaches TIMEOUT_CYCLES without layer_done=1: set status[2], set layer_start<=0, and go to RELEASE. The flow then continues normally, so scan and result still occur; missing entries flag status[1].
  - RELEASE also aborts to SCAN after TIMEOUT_CYCLES if layer_done stays high.
- Undefined: no counter. RUN and RELEASE wait indefinitely, and status[2] is constant 0.

Test Plan:
- Scores to addr 0..9 = 12,40,7,200,3,199,0,55,200,1, then done pulse held until start low → class_valid with class_id=3, class_score=200 (tie with 8 resolved to lower index), status=000, valid NUM_CLASSES cycles after done falls.
- All ten writes = 0 → class_id=0, class_score=0, status=000.
- Writes to addr 0..8 only plus one write to addr 12 with data 250 → result from entries 0..8, status=011, score 250 not used.
- class_ready held low 20 cycles after valid → class_id/class_score stable for all 20 cycles. Ready high → valid low next cycle, busy low, and a new go is accepted.
- go pulsed while in RUN and SCAN → no restart, layer_start single continuous high period. rst asserted mid-SCAN → all outputs 0 the next cycle, layer_start=0.
- With FC_SCORE_TIMEOUT_EN, TIMEOUT_CYCLES=64, layer_done never asserted → layer_start low after 64 RUN cycles, status[2]=1, status[1]=1, result class_id=0. Without the macro, the same stimulus stays in RUN with busy=1 indefinitely.

Source files
------------

// File: rtl/fc_score_argmax.sv
// fc_score_argmax: drives the start/done handshake of the final fully-connected layer, captures
// its per-neuron score writes, then scans the scores and presents the argmax on valid/ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   go                one-cycle request to run an inference (honoured only when idle)
//   busy              high in every state except idle
//   layer_start       start level to the producer layer
//   layer_wr_*        producer write port (addr = neuron index, data = unsigned score)
//   layer_done        producer done level
//   class_id/score    winning class index and its score
//   class_valid/ready result handshake
//   status            sticky flags: [0] range error, [1] missing score, [2] timeout
//
// Optional: define FC_SCORE_TIMEOUT_EN to add the TIMEOUT_CYCLES watchdog on RUN and RELEASE.
module fc_score_argmax #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CLASS_W     = 4
`ifdef FC_SCORE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  output logic               busy,
  output logic               layer_start,
  input  logic [ADDR_W-1:0]  layer_wr_addr,
  input  logic [DATA_W-1:0]  layer_wr_data,
  input  logic               layer_wr_en,
  input  logic               layer_done,
  output logic [CLASS_W-1:0] class_id,
  output logic [DATA_W-1:0]  class_score,
  output logic               class_valid,
  input  logic               class_ready,
  output logic [2:0]         status
);

  typedef enum logic [2:0] {StIdle, StRun, StRelease, StScan, StHold} state_e;

  state_e                   state_q, state_d;
  logic                     layer_start_q, layer_start_d;
  logic [NUM_CLASSES-1:0]   written_q, written_d;
  logic [2:0]               status_q, status_d;
  logic [CLASS_W-1:0]       idx_q, idx_d;
  logic [CLASS_W-1:0]       best_id_q, best_id_d;
  logic [DATA_W-1:0]        best_score_q, best_score_d;
  logic [CLASS_W-1:0]       class_id_q, class_id_d;
  logic [DATA_W-1:0]        class_score_q, class_score_d;
  logic                     class_valid_q, class_valid_d;
  logic [DATA_W-1:0]        score_q [NUM_CLASSES];

  logic                     in_range;
  logic                     sel_written;
  logic [DATA_W-1:0]        sel_score;
  logic                     scan_take;
  logic                     scan_last;

`ifdef FC_SCORE_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_hit;
  assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  assign in_range  = (layer_wr_addr < ADDR_W'(NUM_CLASSES));
  assign scan_last = (idx_q == CLASS_W'(NUM_CLASSES - 1));
  assign scan_take = (sel_score > best_score_q);

  // Scan read mux; unwritten entries read as zero.
  always_comb begin
    sel_written = 1'b0;
    sel_score   = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (idx_q == CLASS_W'(i)) begin
        sel_written = written_q[i];
        sel_score   = written_q[i] ? score_q[i] : '0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    layer_start_d = layer_start_q;
    written_d     = written_q;
    status_d      = status_q;
    idx_d         = idx_q;
    best_id_d     = best_id_q;
    best_score_d  = best_score_q;
    class_id_d    = class_id_q;
    class_score_d = class_score_q;
    class_valid_d = class_valid_q;
`ifdef FC_SCORE_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (go) begin
          written_d     = '0;
          status_d      = '0;
          layer_start_d = 1'b1;
          state_d       = StRun;
`ifdef FC_SCORE_TIMEOUT_EN
          tmo_d         = '0;
`endif
        end
      end
      StRun: begin
        if (layer_wr_en) begin
          if (in_range) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              if (layer_wr_addr == ADDR_W'(i)) written_d[i] = 1'b1;
            end
          end else begin
            status_d[0] = 1'b1;
          end
        end
        if (layer_done) begin
          layer_start_d = 1'b0;
          state_d       = StRelease;
        end
`ifdef FC_SCORE_TIMEOUT_EN
        else if (tmo_hit) begin
          status_d[2]   = 1'b1;
          layer_start_d = 1'b0;
          state_d       = StRelease;
        end
        // Restart the count for RELEASE on exit.
        tmo_d = (state_d == StRelease) ? '0 : tmo_q + 16'd1;
`endif
      end
      StRelease: begin
        // Producer drops done when it is back to idle.
        if (!layer_done) begin
          idx_d        = '0;
          best_id_d    = '0;
          best_score_d = '0;
          state_d      = StScan;
        end
`ifdef FC_SCORE_TIMEOUT_EN
        else if (tmo_hit) begin
          status_d[2]  = 1'b1;
          idx_d        = '0;
          best_id_d    = '0;
          best_score_d = '0;
          state_d      = StScan;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      StScan: begin
        if (!sel_written) status_d[1] = 1'b1;
        // Strict compare keeps the lowest index on ties.
        if (scan_take) begin
          best_id_d    = idx_q;
          best_score_d = sel_score;
        end
        if (scan_last) begin
          class_id_d    = scan_take ? idx_q : best_id_q;
          class_score_d = scan_take ? sel_score : best_score_q;
          class_valid_d = 1'b1;
          state_d       = StHold;
        end else begin
          idx_d = idx_q + CLASS_W'(1);
        end
      end
      StHold: begin
        if (class_ready) begin
          class_valid_d = 1'b0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      layer_start_q <= 1'b0;
      written_q     <= '0;
      status_q      <= '0;
      idx_q         <= '0;
      best_id_q     <= '0;
      best_score_q  <= '0;
      class_id_q    <= '0;
      class_score_q <= '0;
      class_valid_q <= 1'b0;
`ifdef FC_SCORE_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      layer_start_q <= layer_start_d;
      written_q     <= written_d;
      status_q      <= status_d;
      idx_q         <= idx_d;
      best_id_q     <= best_id_d;
      best_score_q  <= best_score_d;
      class_id_q    <= class_id_d;
      class_score_q <= class_score_d;
      class_valid_q <= class_valid_d;
`ifdef FC_SCORE_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  // Score buffer needs no reset: entries are only read when their written bit is set.
  always_ff @(posedge clk) begin
    if (state_q == StRun && layer_wr_en) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (layer_wr_addr == ADDR_W'(i)) score_q[i] <= layer_wr_data;
      end
    end
  end

  assign busy        = (state_q != StIdle);
  assign layer_start = layer_start_q;
  assign class_id    = class_id_q;
  assign class_score = class_score_q;
  assign class_valid = class_valid_q;
  assign status      = status_q;

endmodule
